// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates one byte-wide RAM port between instruction fetch
// (32-bit word reads) and the MEM stage (byte/half/word loads and stores).
// Each request is serialised into little-endian byte accesses; read bytes
// arrive one cycle after their address and are reassembled here.
//
// Optional feature (macro MEM_CTRL_IO_STALL_EN): stores into the IO region
// (addr[17:16] == IO_HI) hold off while io_buffer_full_i is high.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global ready; low freezes the block (no RAM writes)
//   if_req_i/if_addr_i/if_abort_i   fetch request, word address, redirect
//   if_done_o/if_inst_o             fetch completion pulse, instruction
//   mem_req_i/mem_we_i/mem_size_i/mem_addr_i/mem_wdata_i   MEM request
//   mem_done_o/mem_rdata_o          MEM completion pulse, load data
//   ram_a_o/ram_dout_o/ram_wr_o/ram_din_i   byte RAM bus
//   io_buffer_full_i  IO output buffer full
//   busy_o            state is not IDLE
module mem_ctrl #(
    parameter int          ADDR_W = 32,
    parameter logic [1:0]  IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_abort_i,
    output logic              if_done_o,
    output logic [31:0]       if_inst_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i,
    input  logic              io_buffer_full_i,
    output logic              busy_o
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [2:0]        nbytes;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf;
    logic [31:0]       if_inst_q, mem_rdata_q;

    logic              accept_if, accept_mem, cap, last;
    logic              io_region, io_stall;
    logic [1:0]        byte_idx;
    logic [31:0]       assembled;

    function automatic logic [2:0] size_to_n(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        r[8*idx +: 8] = b;
        return r;
    endfunction

    // Byte arriving now belongs to the address issued last cycle (cnt-1).
    assign last      = (cnt == nbytes);
    assign byte_idx  = cnt[1:0] - 2'd1;
    assign assembled = put_byte(rbuf, byte_idx, ram_din_i);
    assign io_region = (addr_q[17:16] == IO_HI);

`ifdef MEM_CTRL_IO_STALL_EN
    assign io_stall = io_region && io_buffer_full_i;
`else
    // Stall path disabled; inputs are referenced but masked off.
    assign io_stall = 1'b0 & io_region & io_buffer_full_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else if (rdy) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ram_a_o    = '0;
        ram_dout_o = 8'h00;
        ram_wr_o   = 1'b0;
        if_done_o  = 1'b0;
        mem_done_o = 1'b0;
        accept_if  = 1'b0;
        accept_mem = 1'b0;
        cap        = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = 3'd0;
                if (mem_req_i) begin
                    accept_mem = 1'b1;
                    state_nxt  = mem_we_i ? MEM_WR : MEM_RD;
                end else if (if_req_i && !if_abort_i) begin
                    accept_if = 1'b1;
                    state_nxt = IF_RD;
                end
            end
            IF_RD, MEM_RD: begin
                if (!last) begin
                    ram_a_o = addr_q + ADDR_W'(cnt);
                    cnt_nxt = cnt + 3'd1;
                    cap     = (cnt != 3'd0);
                end else begin
                    state_nxt = DONE;
                    if (state == MEM_RD)
                        mem_done_o = 1'b1;
                    else
                        if_done_o = !if_abort_i;
                end
                // A redirect kills the fetch in any cycle, including the last.
                if (state == IF_RD && if_abort_i)
                    state_nxt = DONE;
            end
            MEM_WR: begin
                if (!last) begin
                    ram_a_o    = addr_q + ADDR_W'(cnt);
                    ram_dout_o = wdata_q[8*cnt[1:0] +: 8];
                    if (!io_stall) begin
                        ram_wr_o = rdy;
                        cnt_nxt  = cnt + 3'd1;
                    end
                end else begin
                    mem_done_o = 1'b1;
                    state_nxt  = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Held result registers are outputs and therefore cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_inst_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else if (rdy) begin
            if (if_done_o)
                if_inst_q <= assembled;
            if (mem_done_o && state == MEM_RD)
                mem_rdata_q <= assembled;
        end
    end

    // Request capture and byte assembly; rbuf starts at zero so narrow
    // loads come out zero-extended.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (accept_mem) begin
                addr_q  <= mem_addr_i;
                nbytes  <= size_to_n(mem_size_i);
                wdata_q <= mem_wdata_i;
                rbuf    <= 32'h0;
            end else if (accept_if) begin
                addr_q  <= if_addr_i;
                nbytes  <= 3'd4;
                rbuf    <= 32'h0;
            end else if (cap) begin
                rbuf    <= assembled;
            end
        end
    end

    assign if_inst_o   = if_done_o ? assembled : if_inst_q;
    assign mem_rdata_o = (mem_done_o && state == MEM_RD) ? assembled : mem_rdata_q;
    assign busy_o      = (state != IDLE);

endmodule
